// File: rtl/anim_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | anim_sequencer_if                                                        |
// | Frame timing, host config handshake and renderer outputs of the          |
// | animation sequencer.                                                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface anim_sequencer_if #(
    parameter int SEL_BITS    = 1,
    parameter int SCROLL_BITS = 6
);
    logic                   frame_start;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [1:0]             cfg_addr;
    logic [7:0]             cfg_data;
    logic [SEL_BITS-1:0]    frame_sel;
    logic [SCROLL_BITS-1:0] scroll_x;
    logic                   anim_tick;
    logic                   running;

    modport master (
        output frame_start, cfg_valid, cfg_addr, cfg_data,
        input  cfg_ready, frame_sel, scroll_x, anim_tick, running
    );

    modport slave (
        input  frame_start, cfg_valid, cfg_addr, cfg_data,
        output cfg_ready, frame_sel, scroll_x, anim_tick, running
    );
endinterface
`default_nettype wire

// File: rtl/anim_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | anim_sequencer                                                           |
// | Per-frame animation step / horizontal scroll controller with a one-entry |
// | config buffer that is only applied at frame boundaries.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module anim_sequencer #(
    parameter int NUM_FRAMES   = 2,
    parameter int SEL_BITS     = 1,
    parameter int HOLD_BITS    = 5,
    parameter int DEFAULT_HOLD = 16,
    parameter int SCROLL_BITS  = 6
) (
    input  logic clk,
    input  logic rst,
    anim_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_STOP = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [1:0]             ADDR_HOLD  = 2'd0;
    localparam logic [1:0]             ADDR_STEP  = 2'd1;
    localparam logic [1:0]             ADDR_CTRL  = 2'd2;
    localparam logic [SEL_BITS-1:0]    LAST_SEL   = SEL_BITS'(NUM_FRAMES - 1);
    localparam logic [SEL_BITS-1:0]    SEL_ONE    = SEL_BITS'(1);
    localparam logic [HOLD_BITS-1:0]   HOLD_ONE   = HOLD_BITS'(1);
    localparam logic [HOLD_BITS-1:0]   HOLD_RST   = HOLD_BITS'(DEFAULT_HOLD);
    localparam logic [SCROLL_BITS-1:0] STEP_RST   = SCROLL_BITS'(1);

    state_t                 state_q, state_d;
    logic [HOLD_BITS-1:0]   hold_q, hold_d;
    logic [HOLD_BITS-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SCROLL_BITS-1:0] step_q, step_d;
    logic [SEL_BITS-1:0]    frame_sel_q, frame_sel_d;
    logic [SCROLL_BITS-1:0] scroll_x_q, scroll_x_d;
    logic                   anim_tick_q, anim_tick_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [1:0]             pend_addr_q, pend_addr_d;
    logic [7:0]             pend_data_q, pend_data_d;

    logic                   advance;
    logic [HOLD_BITS-1:0]   hold_last;
    logic                   unused_data;

    assign unused_data   = ^pend_data_q;
    assign hold_last     = ((hold_q == '0) ? HOLD_ONE : hold_q) - HOLD_ONE;

    assign bus.cfg_ready = ~pend_valid_q;
    assign bus.frame_sel = frame_sel_q;
    assign bus.scroll_x  = scroll_x_q;
    assign bus.anim_tick = anim_tick_q;
    assign bus.running   = (state_q == ST_RUN);

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_cnt_d   = hold_cnt_q;
        step_d       = step_q;
        frame_sel_d  = frame_sel_q;
        scroll_x_d   = scroll_x_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        advance      = 1'b0;

        // The advance decision always sees the register values from before any write applied this frame.
        if (bus.frame_start) begin
            case (state_q)
                ST_RUN: begin
                    if (hold_cnt_q == hold_last) begin
                        advance    = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_ONE;
                    end
                end
                ST_STEP: begin
                    advance    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = ST_STOP;
                end
                default: ;
            endcase
        end

        if (advance) begin
            frame_sel_d = (frame_sel_q == LAST_SEL) ? '0 : frame_sel_q + SEL_ONE;
            scroll_x_d  = scroll_x_q + step_q;
        end

        if (bus.frame_start && pend_valid_q) begin
            pend_valid_d = 1'b0;
            case (pend_addr_q)
                ADDR_HOLD: begin
                    hold_d     = pend_data_q[HOLD_BITS-1:0];
                    hold_cnt_d = '0;
                end
                ADDR_STEP: step_d = pend_data_q[SCROLL_BITS-1:0];
                ADDR_CTRL: begin
                    if (pend_data_q[0])      state_d = ST_RUN;
                    else if (pend_data_q[1]) state_d = ST_STEP;
                    else                     state_d = ST_STOP;
                    // Rewind wins over a same-frame advance, including its tick.
                    if (pend_data_q[2]) begin
                        frame_sel_d = '0;
                        scroll_x_d  = '0;
                        hold_cnt_d  = '0;
                        advance     = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        anim_tick_d = advance;

        if (bus.cfg_valid && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = bus.cfg_addr;
            pend_data_d  = bus.cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            hold_q       <= HOLD_RST;
            hold_cnt_q   <= '0;
            step_q       <= STEP_RST;
            frame_sel_q  <= '0;
            scroll_x_q   <= '0;
            anim_tick_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_cnt_q   <= hold_cnt_d;
            step_q       <= step_d;
            frame_sel_q  <= frame_sel_d;
            scroll_x_q   <= scroll_x_d;
            anim_tick_q  <= anim_tick_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_anim_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_anim_sequencer                                                        |
// | Self-checking bench: vector table, directed sequences, random vs model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_anim_sequencer;

    localparam int NUM_FRAMES   = 2;
    localparam int SEL_BITS     = 1;
    localparam int HOLD_BITS    = 5;
    localparam int DEFAULT_HOLD = 16;
    localparam int SCROLL_BITS  = 6;
    localparam int SCROLL_MOD   = 1 << SCROLL_BITS;
    localparam int N_VEC        = 30;
    localparam int N_RAND       = 3000;

    localparam int M_RUN  = 0;
    localparam int M_STOP = 1;
    localparam int M_STEP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    anim_sequencer_if #(.SEL_BITS(SEL_BITS), .SCROLL_BITS(SCROLL_BITS)) bus_if ();

    anim_sequencer #(
        .NUM_FRAMES  (NUM_FRAMES),
        .SEL_BITS    (SEL_BITS),
        .HOLD_BITS   (HOLD_BITS),
        .DEFAULT_HOLD(DEFAULT_HOLD),
        .SCROLL_BITS (SCROLL_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    typedef struct {
        bit         rst;
        bit         fs;
        bit         v;
        logic [1:0] a;
        logic [7:0] d;
        int         sel;
        int         scr;
        bit         tick;
        bit         run;
        bit         rdy;
    } vec_t;

    typedef struct packed {
        logic [1:0] a;
        logic [7:0] d;
    } wr_t;

    vec_t tbl [N_VEC];
    int   n_total = 0;
    int   n_pass  = 0;

    // Behavioural reference state
    int  m_sel, m_scroll, m_hold, m_step, m_cnt, m_mode;
    bit  m_tick;
    wr_t pend [$];

    function automatic vec_t vec(bit r, bit fs, bit v, logic [1:0] a, logic [7:0] d,
                                 int sel, int scr, bit tick, bit run, bit rdy);
        vec_t t;
        t.rst = r; t.fs = fs; t.v = v; t.a = a; t.d = d;
        t.sel = sel; t.scr = scr; t.tick = tick; t.run = run; t.rdy = rdy;
        return t;
    endfunction

    task automatic drive(bit r, bit fs, bit v, logic [1:0] a, logic [7:0] d);
        rst                = r;
        bus_if.frame_start = fs;
        bus_if.cfg_valid   = v;
        bus_if.cfg_addr    = a;
        bus_if.cfg_data    = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_outs(string name, int sel, int scr, bit tick, bit run, bit rdy);
        n_total++;
        if (bus_if.frame_sel === SEL_BITS'(sel) && bus_if.scroll_x === SCROLL_BITS'(scr) &&
            bus_if.anim_tick === tick && bus_if.running === run && bus_if.cfg_ready === rdy)
            n_pass++;
        else
            $display("FAIL %s: sel/scroll/tick/run/rdy got %0d/%0d/%b/%b/%b expected %0d/%0d/%b/%b/%b",
                     name, bus_if.frame_sel, bus_if.scroll_x, bus_if.anim_tick, bus_if.running,
                     bus_if.cfg_ready, sel, scr, tick, run, rdy);
    endtask

    // One clock of the animation rules, written against the model's integer state.
    task automatic model_step(bit r, bit fs, bit v, logic [1:0] a, logic [7:0] d);
        bit  adv;
        bit  was_empty;
        int  period;
        wr_t w;
        if (r) begin
            m_sel = 0; m_scroll = 0; m_hold = DEFAULT_HOLD; m_step = 1;
            m_cnt = 0; m_mode = M_RUN; m_tick = 0;
            pend.delete();
            return;
        end
        was_empty = (pend.size() == 0);
        adv = 0;
        if (fs) begin
            period = (m_hold == 0) ? 1 : m_hold;
            if (m_mode == M_RUN) begin
                if (m_cnt + 1 == period) begin adv = 1; m_cnt = 0; end
                else m_cnt = m_cnt + 1;
            end else if (m_mode == M_STEP) begin
                adv = 1; m_cnt = 0; m_mode = M_STOP;
            end
            if (adv) begin
                m_sel    = (m_sel + 1) % NUM_FRAMES;
                m_scroll = (m_scroll + m_step) % SCROLL_MOD;
            end
            if (!was_empty) begin
                w = pend.pop_front();
                case (w.a)
                    2'd0: begin m_hold = int'(w.d) % (1 << HOLD_BITS); m_cnt = 0; end
                    2'd1: m_step = int'(w.d) % SCROLL_MOD;
                    2'd2: begin
                        m_mode = w.d[0] ? M_RUN : (w.d[1] ? M_STEP : M_STOP);
                        if (w.d[2]) begin
                            m_sel = 0; m_scroll = 0; m_cnt = 0; adv = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
        m_tick = adv;
        if (v && was_empty) pend.push_back({a, d});
    endtask

    initial begin
        int ticks;
        int tick_at [$];
        bit r, fs, v;
        logic [1:0] a;
        logic [7:0] d;

        //             rst fs v  addr  data    sel scr tick run rdy
        tbl[0]  = vec(1, 0, 0, 2'd0, 8'h00,  0,  0, 0, 1, 1);
        tbl[1]  = vec(0, 0, 1, 2'd0, 8'h01,  0,  0, 0, 1, 0);
        tbl[2]  = vec(0, 1, 0, 2'd0, 8'h00,  0,  0, 0, 1, 1);
        tbl[3]  = vec(0, 1, 0, 2'd0, 8'h00,  1,  1, 1, 1, 1);
        tbl[4]  = vec(0, 0, 0, 2'd0, 8'h00,  1,  1, 0, 1, 1);
        tbl[5]  = vec(0, 1, 1, 2'd1, 8'h45,  0,  2, 1, 1, 0);
        tbl[6]  = vec(0, 1, 0, 2'd0, 8'h00,  1,  3, 1, 1, 1);
        tbl[7]  = vec(0, 1, 0, 2'd0, 8'h00,  0,  8, 1, 1, 1);
        tbl[8]  = vec(0, 0, 1, 2'd2, 8'hF8,  0,  8, 0, 1, 0);
        tbl[9]  = vec(0, 1, 0, 2'd0, 8'h00,  1, 13, 1, 0, 1);
        tbl[10] = vec(0, 1, 0, 2'd0, 8'h00,  1, 13, 0, 0, 1);
        tbl[11] = vec(0, 0, 1, 2'd2, 8'h06,  1, 13, 0, 0, 0);
        tbl[12] = vec(0, 1, 0, 2'd0, 8'h00,  0,  0, 0, 0, 1);
        tbl[13] = vec(0, 1, 0, 2'd0, 8'h00,  1,  5, 1, 0, 1);
        tbl[14] = vec(0, 0, 1, 2'd3, 8'hFF,  1,  5, 0, 0, 0);
        tbl[15] = vec(0, 1, 0, 2'd0, 8'h00,  1,  5, 0, 0, 1);
        tbl[16] = vec(0, 0, 1, 2'd2, 8'h05,  1,  5, 0, 0, 0);
        tbl[17] = vec(0, 1, 0, 2'd0, 8'h00,  0,  0, 0, 1, 1);
        tbl[18] = vec(0, 1, 0, 2'd0, 8'h00,  1,  5, 1, 1, 1);
        tbl[19] = vec(0, 0, 1, 2'd2, 8'h05,  1,  5, 0, 1, 0);
        tbl[20] = vec(0, 1, 0, 2'd0, 8'h00,  0,  0, 0, 1, 1);
        tbl[21] = vec(0, 0, 1, 2'd0, 8'h00,  0,  0, 0, 1, 0);
        tbl[22] = vec(0, 1, 0, 2'd0, 8'h00,  1,  5, 1, 1, 1);
        tbl[23] = vec(0, 1, 0, 2'd0, 8'h00,  0, 10, 1, 1, 1);
        tbl[24] = vec(0, 1, 1, 2'd1, 8'h3F,  1, 15, 1, 1, 0);
        tbl[25] = vec(0, 1, 0, 2'd0, 8'h00,  0, 20, 1, 1, 1);
        tbl[26] = vec(0, 1, 0, 2'd0, 8'h00,  1, 19, 1, 1, 1);
        tbl[27] = vec(0, 0, 1, 2'd0, 8'h03,  1, 19, 0, 1, 0);
        tbl[28] = vec(1, 0, 0, 2'd0, 8'h00,  0,  0, 0, 1, 1);
        tbl[29] = vec(0, 1, 0, 2'd0, 8'h00,  0,  0, 0, 1, 1);

        drive(1, 0, 0, 2'd0, 8'h00);
        for (int i = 0; i < N_VEC; i++) begin
            drive(tbl[i].rst, tbl[i].fs, tbl[i].v, tbl[i].a, tbl[i].d);
            cyc();
            check_outs($sformatf("vec%0d", i), tbl[i].sel, tbl[i].scr, tbl[i].tick,
                       tbl[i].run, tbl[i].rdy);
        end

        // Default hold of 16: 40 pulses advance exactly after pulses 16 and 32.
        drive(1, 0, 0, 2'd0, 8'h00); cyc();
        for (int p = 1; p <= 40; p++) begin
            drive(0, 1, 0, 2'd0, 8'h00); cyc();
            if (bus_if.anim_tick === 1'b1) tick_at.push_back(p);
            if (p == 16) check_outs("hold16_first_adv", 1, 1, 1, 1, 1);
            drive(0, 0, 0, 2'd0, 8'h00); cyc();
            if (p == 16) check_outs("hold16_tick_drop", 1, 1, 0, 1, 1);
            cyc();
        end
        check("hold16_tick_count", tick_at.size(), 2);
        if (tick_at.size() == 2) begin
            check("hold16_tick1_pulse", tick_at[0], 16);
            check("hold16_tick2_pulse", tick_at[1], 32);
        end
        check_outs("hold16_final", 0, 2, 0, 1, 1);

        // Back-to-back writes with cfg_valid held: the second waits for the first to apply.
        drive(0, 0, 1, 2'd1, 8'h03); cyc();
        check("b2b_first_accepted_rdy", int'(bus_if.cfg_ready), 0);
        drive(0, 0, 1, 2'd0, 8'h01);
        for (int k = 0; k < 3; k++) cyc();
        check("b2b_second_waits_rdy", int'(bus_if.cfg_ready), 0);
        drive(0, 1, 1, 2'd0, 8'h01); cyc();
        check("b2b_rdy_after_apply", int'(bus_if.cfg_ready), 1);
        drive(0, 0, 1, 2'd0, 8'h01); cyc();
        check("b2b_second_accepted_rdy", int'(bus_if.cfg_ready), 0);
        drive(0, 1, 0, 2'd0, 8'h00); cyc();
        check_outs("b2b_second_applied", 0, 2, 0, 1, 1);
        drive(0, 1, 0, 2'd0, 8'h00); cyc();
        check_outs("b2b_both_effective", 1, 5, 1, 1, 1);

        // A reset with a write pending discards that write.
        drive(0, 0, 1, 2'd0, 8'h01); cyc();
        drive(1, 0, 0, 2'd0, 8'h00); cyc();
        check_outs("rst_pending_state", 0, 0, 0, 1, 1);
        ticks = 0;
        for (int p = 0; p < 4; p++) begin
            drive(0, 1, 0, 2'd0, 8'h00); cyc();
            ticks += int'(bus_if.anim_tick);
        end
        check("rst_pending_discarded", ticks, 0);

        // Random traffic against the reference model.
        drive(1, 0, 0, 2'd0, 8'h00);
        model_step(1, 0, 0, 2'd0, 8'h00);
        cyc();
        for (int i = 0; i < N_RAND; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            fs = ($urandom_range(0, 3) == 0);
            v  = ($urandom_range(0, 2) == 0);
            a  = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            if (a == 2'd0) d[4:0] = 5'($urandom_range(0, 3));
            drive(r, fs, v, a, d);
            model_step(r, fs, v, a, d);
            cyc();
            check_outs($sformatf("rand%0d", i), m_sel, m_scroll, m_tick,
                       m_mode == M_RUN, pend.size() == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
